// File: rtl/mul8x8_seq4_ctrl.sv
// mul8x8_seq4_ctrl: 8x8 unsigned multiply by sequencing one shared external 4x4 core.
// Latency: 4 edges from acceptance (3 with SKIP_LL); a zero operand with ZERO_SKIP finishes on the acceptance edge.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake, in_a/in_b captured on acceptance
//   mul_a/mul_b/mul_r   - registered nibble operands to the 4x4 core, its combinational product back
//   out_valid/out_ready - result handshake, out_p (saturated 16-bit) and out_ovf
module mul8x8_seq4_ctrl #(
  parameter bit ZERO_SKIP = 1'b1,
  parameter bit SKIP_LL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Truncating variants drop AL*BL and start the schedule one step later.
  localparam logic [1:0] K_FIRST = SKIP_LL ? 2'd1 : 2'd0;

  state_t      r_state;
  logic [1:0]  r_k;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [16:0] r_acc;
  logic [3:0]  r_mul_a;
  logic [3:0]  r_mul_b;
  logic [15:0] r_out_p;
  logic        r_out_ovf;
  logic        r_out_valid;

  logic        w_skip;
  logic [1:0]  w_k_nxt;
  logic [16:0] w_pp;
  logic [16:0] w_acc_nxt;

  // Step k pairs A nibble k[1] with B nibble k[0]: (AL,BL) (AL,BH) (AH,BL) (AH,BH).
  function automatic logic [3:0] nib_a(input logic [7:0] a, input logic [1:0] k);
    return k[1] ? a[7:4] : a[3:0];
  endfunction

  function automatic logic [3:0] nib_b(input logic [7:0] b, input logic [1:0] k);
    return k[0] ? b[7:4] : b[3:0];
  endfunction

  assign w_skip  = ZERO_SKIP && ((in_a == 8'd0) || (in_b == 8'd0));
  assign w_k_nxt = r_k + 2'd1;

  // Partial product weight: k0 -> 1, k1/k2 -> 16, k3 -> 256.
  always_comb begin
    w_pp = 17'd0;
    case (r_k)
      2'd0:    w_pp = {9'd0, mul_r};
      2'd3:    w_pp = {1'b0, mul_r, 8'd0};
      default: w_pp = {5'd0, mul_r, 4'd0};
    endcase
  end

  // 17 bits so an approximate core that overshoots 16'hFFFF is still visible.
  assign w_acc_nxt = r_acc + w_pp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= 2'd0;
      r_a         <= 8'd0;
      r_b         <= 8'd0;
      r_acc       <= 17'd0;
      r_mul_a     <= 4'd0;
      r_mul_b     <= 4'd0;
      r_out_p     <= 16'd0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_acc <= 17'd0;
            if (w_skip) begin
              r_state     <= S_DONE;
              r_out_p     <= 16'd0;
              r_out_ovf   <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_BUSY;
              r_k     <= K_FIRST;
              r_mul_a <= nib_a(in_a, K_FIRST);
              r_mul_b <= nib_b(in_b, K_FIRST);
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          if (r_k == 2'd3) begin
            r_state     <= S_DONE;
            r_k         <= 2'd0;
            r_mul_a     <= 4'd0;
            r_mul_b     <= 4'd0;
            r_out_p     <= w_acc_nxt[16] ? 16'hFFFF : w_acc_nxt[15:0];
            r_out_ovf   <= w_acc_nxt[16];
            r_out_valid <= 1'b1;
          end else begin
            r_k     <= w_k_nxt;
            r_mul_a <= nib_a(r_a, w_k_nxt);
            r_mul_b <= nib_b(r_b, w_k_nxt);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign out_valid = r_out_valid;
  assign out_p     = r_out_p;
  assign out_ovf   = r_out_ovf;

endmodule
